// File: rtl/note_arrow_left.sv
// rtl/note_arrow_left.sv - falling left-arrow note: spawn, scroll, judge press, draw sprite
module note_arrow_left #(
  parameter int IX    = 50,
  parameter int TY    = 400,
  parameter int SY    = 15,
  parameter int SPEED = 2,
  parameter int WIN   = 12,
  parameter int FLASH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_clk,
  input  logic       animate,
  input  logic       spawn,
  input  logic       press,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       arrow,
  output logic       busy,
  output logic       hit,
  output logic       miss
);

  localparam logic [9:0] Y_LO    = 10'(TY - WIN);
  localparam logic [9:0] Y_HI    = 10'(TY + WIN);
  localparam logic [9:0] Y_SPAWN = 10'(SY);
  localparam logic [9:0] Y_STEP  = 10'(SPEED);
  localparam int         CW      = (FLASH < 2) ? 1 : $clog2(FLASH);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FALL, S_FLASH} state_t;

  state_t        state, state_n;
  logic [9:0]    yc, yc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sync1, sync2, prev;
  logic          press_edge, in_win, past_win;
  logic          hit_d, miss_d;
  logic          pix_on;
  int            xi, yi, ci;

  // Two-flop synchroniser on the raw button plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= press;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press_edge = sync2 & ~prev;
  assign in_win     = (yc >= Y_LO) && (yc <= Y_HI);
  assign past_win   = (yc > Y_HI);

  // State register with the note position and flash frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      yc    <= Y_SPAWN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      yc    <= yc_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: a judged hit wins over both the miss check and the frame step
  always_comb begin
    state_n = state;
    yc_n    = yc;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (spawn) begin
          state_n = S_FALL;
          yc_n    = Y_SPAWN;
        end
      end
      S_FALL: begin
        if (press_edge && in_win) begin
          state_n = S_FLASH;
          cnt_n   = '0;
        end else if (past_win) begin
          state_n = S_IDLE;
        end else if (animate) begin
          yc_n = yc + Y_STEP;
        end
      end
      S_FLASH: begin
        if (animate) begin
          if (cnt == CNT_LAST) state_n = S_IDLE;
          else                 cnt_n   = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and the judge conditions
  always_comb begin
    busy   = (state != S_IDLE);
    hit_d  = (state == S_FALL) && press_edge && in_win;
    miss_d = (state == S_FALL) && !hit_d && past_win;
  end

  // Register the judge pulses so each is exactly one cycle wide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end else begin
      hit  <= hit_d;
      miss <= miss_d;
    end
  end

  // Sprite coverage: rectangular shaft plus a ten-column stepped head pointing left
  always_comb begin
    xi     = int'(x);
    yi     = int'(y);
    ci     = int'(yc);
    pix_on = 1'b0;
    if (xi >= IX - 2 && xi < IX + 12 && yi >= ci - 6 && yi < ci + 6)
      pix_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (xi >= IX - 12 + i && xi < IX - 9 + i && yi >= ci - 1 - i && yi < ci + 1 + i)
        pix_on = 1'b1;
    end
  end

  // Pixel output only advances on pixel-enable cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          arrow <= 1'b0;
    else if (pix_clk) arrow <= pix_on & busy;
  end

endmodule
